// File: rtl/fb_pkg.sv
// Shared frame-buffer constants, read-return tags and round-robin pointer encoding.
package fb_pkg;

   localparam int unsigned FB_ADDR_W = 19;
   localparam int unsigned FB_DATA_W = 8;
   localparam int unsigned FB_IMG_X  = 640;
   localparam int unsigned FB_IMG_Y  = 480;
   localparam int unsigned FB_FCNT_W = 20;

   typedef enum logic [1:0] {
      TAG_NONE = 2'd0,
      TAG_DISP = 2'd1,
      TAG_RB   = 2'd2
   } fb_tag_e;

   typedef enum logic {
      RR_WR = 1'b0,
      RR_RB = 1'b1
   } fb_rr_e;

   function automatic logic [FB_FCNT_W-1:0] fcnt_sat_inc(input logic [FB_FCNT_W-1:0] v,
                                                         input logic             inc);
      return (inc && (v != '1)) ? v + FB_FCNT_W'(1) : v;
   endfunction

endpackage

// File: rtl/fb_port_arbiter_if.sv
// Client and RAM-side signal bundle of the frame-buffer port arbiter.
interface fb_port_arbiter_if
   import fb_pkg::*;
#(
   parameter int unsigned ADDR_W = FB_ADDR_W,
   parameter int unsigned DATA_W = FB_DATA_W
);

   logic                 FRAME_START;
   logic                 VBLANK;
   logic                 DISP_REQ;
   logic [ADDR_W-1:0]    DISP_ADDR;
   logic [DATA_W-1:0]    DISP_DATA;
   logic                 WR_VALID;
   logic                 WR_READY;
   logic [ADDR_W-1:0]    WR_ADDR;
   logic [DATA_W-1:0]    WR_DATA;
   logic                 RB_VALID;
   logic                 RB_READY;
   logic [ADDR_W-1:0]    RB_ADDR;
   logic [DATA_W-1:0]    RB_DATA;
   logic                 RB_DATA_VALID;
   logic [ADDR_W-1:0]    RAM_ADDR;
   logic                 RAM_WE;
   logic [DATA_W-1:0]    RAM_WDATA;
   logic [DATA_W-1:0]    RAM_RDATA;
   logic                 WR_STARVED;
   logic [FB_FCNT_W-1:0] FRAME_WR_COUNT;

   modport slave (
      input  FRAME_START, VBLANK, DISP_REQ, DISP_ADDR, WR_VALID, WR_ADDR, WR_DATA,
             RB_VALID, RB_ADDR, RAM_RDATA,
      output DISP_DATA, WR_READY, RB_READY, RB_DATA, RB_DATA_VALID,
             RAM_ADDR, RAM_WE, RAM_WDATA, WR_STARVED, FRAME_WR_COUNT
   );

   modport master (
      output FRAME_START, VBLANK, DISP_REQ, DISP_ADDR, WR_VALID, WR_ADDR, WR_DATA,
             RB_VALID, RB_ADDR, RAM_RDATA,
      input  DISP_DATA, WR_READY, RB_READY, RB_DATA, RB_DATA_VALID,
             RAM_ADDR, RAM_WE, RAM_WDATA, WR_STARVED, FRAME_WR_COUNT
   );

endinterface

// File: rtl/fb_rr_grant.sv
// Two-requester round-robin (writer vs readback) that yields entirely while blocked.
module fb_rr_grant
   import fb_pkg::*;
(
   input  logic clk_i,
   input  logic rst_ni,
   input  logic block_i,
   input  logic wr_elig_i,
   input  logic rb_req_i,
   output logic wr_gnt_o,
   output logic rb_gnt_o
);

   fb_rr_e ptr_q, ptr_d;

   // A grant is always a handshake because it already requires the requester's VALID.
   always_comb begin
      wr_gnt_o = 1'b0;
      rb_gnt_o = 1'b0;
      ptr_d    = ptr_q;
      if (!block_i) begin
         if (wr_elig_i && (!rb_req_i || (ptr_q == RR_WR))) begin
            wr_gnt_o = 1'b1;
         end else if (rb_req_i) begin
            rb_gnt_o = 1'b1;
         end
      end
      if (wr_gnt_o) begin
         ptr_d = RR_RB;
      end else if (rb_gnt_o) begin
         ptr_d = RR_WR;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         ptr_q <= RR_WR;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/fb_port_arbiter.sv
// Frame-buffer RAM arbiter: display reads first, writer/readback round-robined,
// registered RAM stage with a tag pipe steering RAM_RDATA back to its requester.
module fb_port_arbiter
   import fb_pkg::*;
#(
   parameter int unsigned ADDR_W       = FB_ADDR_W,
   parameter int unsigned DATA_W       = FB_DATA_W,
   parameter int unsigned STARVE_LIMIT = 1024,
   parameter int unsigned FRAME_LOCK   = 0
) (
   input  logic             CLK_PX,
   input  logic             RST_n,
   fb_port_arbiter_if.slave bus
);

   localparam int unsigned SC_W = $clog2(STARVE_LIMIT + 1);

   logic wr_elig, wr_gnt, rb_gnt;

   logic [ADDR_W-1:0]    ram_addr_q, ram_addr_d;
   logic                 ram_we_q, ram_we_d;
   logic [DATA_W-1:0]    ram_wdata_q, ram_wdata_d;
   fb_tag_e              tag_q, tag_d;
   logic [DATA_W-1:0]    disp_data_q, disp_data_d;
   logic [DATA_W-1:0]    rb_data_q, rb_data_d;
   logic                 rb_dv_q, rb_dv_d;
   logic [SC_W-1:0]      starve_q, starve_d;
   logic [FB_FCNT_W-1:0] fcnt_q, fcnt_d;
   logic [FB_FCNT_W-1:0] fwc_q, fwc_d;
   logic [FB_FCNT_W-1:0] fcnt_inc;

   assign wr_elig = bus.WR_VALID && ((FRAME_LOCK == 0) || bus.VBLANK);

   fb_rr_grant u_rr (
      .clk_i     (CLK_PX),
      .rst_ni    (RST_n),
      .block_i   (bus.DISP_REQ),
      .wr_elig_i (wr_elig),
      .rb_req_i  (bus.RB_VALID),
      .wr_gnt_o  (wr_gnt),
      .rb_gnt_o  (rb_gnt)
   );

   assign fcnt_inc = fcnt_sat_inc(fcnt_q, wr_gnt);

   always_comb begin
      ram_addr_d  = ram_addr_q;
      ram_we_d    = 1'b0;
      ram_wdata_d = ram_wdata_q;
      tag_d       = TAG_NONE;
      if (bus.DISP_REQ) begin
         ram_addr_d = bus.DISP_ADDR;
         tag_d      = TAG_DISP;
      end else if (wr_gnt) begin
         ram_addr_d  = bus.WR_ADDR;
         ram_wdata_d = bus.WR_DATA;
         ram_we_d    = 1'b1;
      end else if (rb_gnt) begin
         ram_addr_d = bus.RB_ADDR;
         tag_d      = TAG_RB;
      end

      // RAM_RDATA belongs to the address registered last cycle, i.e. to tag_q.
      disp_data_d = disp_data_q;
      rb_data_d   = rb_data_q;
      rb_dv_d     = 1'b0;
      case (tag_q)
         TAG_DISP: disp_data_d = bus.RAM_RDATA;
         TAG_RB: begin
            rb_data_d = bus.RAM_RDATA;
            rb_dv_d   = 1'b1;
         end
         default: ;
      endcase

      if (!bus.WR_VALID || wr_gnt) begin
         starve_d = '0;
      end else if (starve_q != SC_W'(STARVE_LIMIT)) begin
         starve_d = starve_q + SC_W'(1);
      end else begin
         starve_d = starve_q;
      end

      fwc_d  = fwc_q;
      fcnt_d = fcnt_inc;
      if (bus.FRAME_START) begin
         fwc_d  = fcnt_inc;
         fcnt_d = FB_FCNT_W'(wr_gnt);
      end
   end

   always_ff @(posedge CLK_PX) begin
      if (!RST_n) begin
         ram_addr_q  <= '0;
         ram_we_q    <= 1'b0;
         ram_wdata_q <= '0;
         tag_q       <= TAG_NONE;
         disp_data_q <= '0;
         rb_data_q   <= '0;
         rb_dv_q     <= 1'b0;
         starve_q    <= '0;
         fcnt_q      <= '0;
         fwc_q       <= '0;
      end else begin
         ram_addr_q  <= ram_addr_d;
         ram_we_q    <= ram_we_d;
         ram_wdata_q <= ram_wdata_d;
         tag_q       <= tag_d;
         disp_data_q <= disp_data_d;
         rb_data_q   <= rb_data_d;
         rb_dv_q     <= rb_dv_d;
         starve_q    <= starve_d;
         fcnt_q      <= fcnt_d;
         fwc_q       <= fwc_d;
      end
   end

   assign bus.WR_READY       = wr_gnt;
   assign bus.RB_READY       = rb_gnt;
   assign bus.RAM_ADDR       = ram_addr_q;
   assign bus.RAM_WE         = ram_we_q;
   assign bus.RAM_WDATA      = ram_wdata_q;
   assign bus.DISP_DATA      = disp_data_q;
   assign bus.RB_DATA        = rb_data_q;
   assign bus.RB_DATA_VALID  = rb_dv_q;
   assign bus.WR_STARVED     = (starve_q == SC_W'(STARVE_LIMIT));
   assign bus.FRAME_WR_COUNT = fwc_q;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Bench for fb_port_arbiter: two instances (FRAME_LOCK 0 and 1) fed identical stimulus,
// each with its own RAM (read data follows RAM_ADDR in the same cycle) and reference model.
module tb_fb_port_arbiter;
   import fb_pkg::*;

   localparam int unsigned AW  = 19;
   localparam int unsigned DW  = 8;
   localparam int          SL  = 16;
   localparam int unsigned MW  = 11;
   localparam int          MSZ = 2048;
   localparam int          FMAX = (1 << 20) - 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n, fs, vb, disp, wv, rv;
   logic [AW-1:0] da, wa, ra;
   logic [DW-1:0] wd;

   fb_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();
   fb_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();

   fb_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL), .FRAME_LOCK(0)) u_dut0 (
      .CLK_PX (clk), .RST_n (rst_n), .bus (bus0));
   fb_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL), .FRAME_LOCK(1)) u_dut1 (
      .CLK_PX (clk), .RST_n (rst_n), .bus (bus1));

   assign bus0.FRAME_START = fs;   assign bus1.FRAME_START = fs;
   assign bus0.VBLANK      = vb;   assign bus1.VBLANK      = vb;
   assign bus0.DISP_REQ    = disp; assign bus1.DISP_REQ    = disp;
   assign bus0.DISP_ADDR   = da;   assign bus1.DISP_ADDR   = da;
   assign bus0.WR_VALID    = wv;   assign bus1.WR_VALID    = wv;
   assign bus0.WR_ADDR     = wa;   assign bus1.WR_ADDR     = wa;
   assign bus0.WR_DATA     = wd;   assign bus1.WR_DATA     = wd;
   assign bus0.RB_VALID    = rv;   assign bus1.RB_VALID    = rv;
   assign bus0.RB_ADDR     = ra;   assign bus1.RB_ADDR     = ra;

   logic [DW-1:0] ram [2][MSZ];
   assign bus0.RAM_RDATA = ram[0][bus0.RAM_ADDR[MW-1:0]];
   assign bus1.RAM_RDATA = ram[1][bus1.RAM_ADDR[MW-1:0]];

   typedef struct {
      logic          wr_ready, rb_ready, ram_we, rb_dv, starved;
      logic [AW-1:0] ram_addr;
      logic [DW-1:0] ram_wdata, disp_data, rb_data;
      logic [19:0]   fwc;
   } smp_t;

   typedef struct {
      bit            turn_rb;
      int            starve, fcnt, fwc;
      logic [AW-1:0] ram_addr;
      bit            ram_we, rb_dv;
      logic [DW-1:0] ram_wdata, disp_data, rb_data;
   } mdl_t;

   typedef struct {
      int            due;
      bit            rb;
      logic [DW-1:0] data;
   } rd_t;

   typedef struct {
      bit disp, wv, rv;
      bit exp_wr, exp_rb;
   } vec_t;

   smp_t          smp [2];
   mdl_t          m [2];
   logic [DW-1:0] ref_mem [2][MSZ];
   rd_t           pq [2][$];
   bit            mvalid;
   int            cyc, n_cmp, n_bad;

   function automatic logic [DW-1:0] pat(input int a);
      return 8'(a * 37 + 11);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   task automatic sample_all();
      smp[0].wr_ready = bus0.WR_READY;  smp[1].wr_ready = bus1.WR_READY;
      smp[0].rb_ready = bus0.RB_READY;  smp[1].rb_ready = bus1.RB_READY;
      smp[0].ram_we   = bus0.RAM_WE;    smp[1].ram_we   = bus1.RAM_WE;
      smp[0].rb_dv    = bus0.RB_DATA_VALID; smp[1].rb_dv = bus1.RB_DATA_VALID;
      smp[0].starved  = bus0.WR_STARVED; smp[1].starved = bus1.WR_STARVED;
      smp[0].ram_addr = bus0.RAM_ADDR;  smp[1].ram_addr = bus1.RAM_ADDR;
      smp[0].ram_wdata = bus0.RAM_WDATA; smp[1].ram_wdata = bus1.RAM_WDATA;
      smp[0].disp_data = bus0.DISP_DATA; smp[1].disp_data = bus1.DISP_DATA;
      smp[0].rb_data  = bus0.RB_DATA;   smp[1].rb_data  = bus1.RB_DATA;
      smp[0].fwc      = bus0.FRAME_WR_COUNT; smp[1].fwc = bus1.FRAME_WR_COUNT;
   endtask

   // Reads snapshot the reference memory when issued and are delivered two cycles later.
   task automatic model_step(input int k);
      bit  lock;
      bit  elig, wg, rg;
      int  inc;
      rd_t e;
      lock = (k == 1);
      m[k].rb_dv = 1'b0;
      while (pq[k].size() > 0 && pq[k][0].due <= cyc) begin
         e = pq[k].pop_front();
         if (e.rb) begin
            m[k].rb_data = e.data;
            m[k].rb_dv   = 1'b1;
         end else begin
            m[k].disp_data = e.data;
         end
      end
      if (mvalid) begin
         chk($sformatf("d%0d_ram_addr", k),  smp[k].ram_addr,  m[k].ram_addr);
         chk($sformatf("d%0d_ram_we", k),    smp[k].ram_we,    m[k].ram_we);
         chk($sformatf("d%0d_ram_wdata", k), smp[k].ram_wdata, m[k].ram_wdata);
         chk($sformatf("d%0d_disp_data", k), smp[k].disp_data, m[k].disp_data);
         chk($sformatf("d%0d_rb_data", k),   smp[k].rb_data,   m[k].rb_data);
         chk($sformatf("d%0d_rb_dv", k),     smp[k].rb_dv,     m[k].rb_dv);
         chk($sformatf("d%0d_starved", k),   smp[k].starved,   32'(m[k].starve == SL));
         chk($sformatf("d%0d_fwc", k),       smp[k].fwc,       m[k].fwc);
      end
      elig = wv && (!lock || vb);
      wg   = !disp && elig && (!rv || !m[k].turn_rb);
      rg   = !disp && rv && !wg;
      if (mvalid && rst_n) begin
         chk($sformatf("d%0d_wr_ready", k), smp[k].wr_ready, wg);
         chk($sformatf("d%0d_rb_ready", k), smp[k].rb_ready, rg);
      end
      if (!rst_n) begin
         m[k] = '{default: 0};
         pq[k].delete();
      end else begin
         m[k].ram_we = 1'b0;
         if (disp) begin
            m[k].ram_addr = da;
            e.due = cyc + 2; e.rb = 1'b0; e.data = ref_mem[k][da[MW-1:0]];
            pq[k].push_back(e);
         end else if (wg) begin
            m[k].ram_addr  = wa;
            m[k].ram_wdata = wd;
            m[k].ram_we    = 1'b1;
            ref_mem[k][wa[MW-1:0]] = wd;
            m[k].turn_rb = 1'b1;
         end else if (rg) begin
            m[k].ram_addr = ra;
            e.due = cyc + 2; e.rb = 1'b1; e.data = ref_mem[k][ra[MW-1:0]];
            pq[k].push_back(e);
            m[k].turn_rb = 1'b0;
         end
         if (!wv || wg) m[k].starve = 0;
         else if (m[k].starve < SL) m[k].starve++;
         inc = (wg && m[k].fcnt < FMAX) ? m[k].fcnt + 1 : m[k].fcnt;
         if (fs) begin
            m[k].fwc  = inc;
            m[k].fcnt = wg ? 1 : 0;
         end else begin
            m[k].fcnt = inc;
         end
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      sample_all();
      model_step(0);
      model_step(1);
      if (!rst_n) mvalid = 1'b1;
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++)
         if (smp[k].ram_we === 1'b1) ram[k][smp[k].ram_addr[MW-1:0]] = smp[k].ram_wdata;
      cyc++;
   endtask

   task automatic idle_inputs();
      fs = 0; vb = 0; disp = 0; wv = 0; rv = 0;
      da = '0; wa = '0; wd = '0; ra = '0;
   endtask

   task automatic do_reset(input int n);
      rst_n = 1'b0;
      repeat (n) cycle();
      rst_n = 1'b1;
   endtask

   initial begin
      vec_t tbl [12];
      int   cnt, starve_at;

      n_cmp = 0; n_bad = 0; cyc = 0; mvalid = 1'b0;
      for (int i = 0; i < MSZ; i++) begin
         ram[0][i] = pat(i); ram[1][i] = pat(i);
         ref_mem[0][i] = pat(i); ref_mem[1][i] = pat(i);
      end
      idle_inputs();
      rst_n = 1'b0;
      @(posedge clk); #1;

      // reset, then idle
      do_reset(3);
      cycle();
      chk("rst_ram_addr", smp[0].ram_addr, 0);
      chk("rst_disp_data", smp[0].disp_data, 0);
      chk("rst_fwc", smp[0].fwc, 0);
      chk("rst_starved", smp[0].starved, 0);
      cnt = 0;
      repeat (100) begin
         cycle();
         if (smp[0].ram_we !== 1'b0 || smp[1].ram_we !== 1'b0) cnt++;
      end
      chk("idle_ram_we", cnt, 0);

      // grant table, pointer starts at WR after reset
      tbl[0]  = '{1, 1, 1, 0, 0};
      tbl[1]  = '{0, 1, 1, 1, 0};
      tbl[2]  = '{0, 1, 1, 0, 1};
      tbl[3]  = '{0, 1, 1, 1, 0};
      tbl[4]  = '{1, 1, 1, 0, 0};
      tbl[5]  = '{0, 1, 1, 0, 1};
      tbl[6]  = '{0, 0, 1, 0, 1};
      tbl[7]  = '{0, 1, 1, 1, 0};
      tbl[8]  = '{0, 1, 0, 1, 0};
      tbl[9]  = '{0, 1, 1, 0, 1};
      tbl[10] = '{0, 0, 0, 0, 0};
      tbl[11] = '{0, 1, 1, 1, 0};
      do_reset(1);
      vb = 1;
      for (int i = 0; i < 12; i++) begin
         disp = tbl[i].disp; wv = tbl[i].wv; rv = tbl[i].rv;
         da = AW'(300 + i); wa = AW'(100 + i); wd = DW'(i); ra = AW'(200 + i);
         cycle();
         chk($sformatf("tbl%0d_wr", i), smp[0].wr_ready, tbl[i].exp_wr);
         chk($sformatf("tbl%0d_rb", i), smp[0].rb_ready, tbl[i].exp_rb);
      end

      // write then readback of the same address
      idle_inputs(); vb = 1;
      wv = 1; wa = AW'('h10); wd = 8'h5A;
      cycle();
      chk("wr_ready", smp[0].wr_ready, 1);
      wv = 0; rv = 1; ra = AW'('h10);
      cycle();
      chk("wr_ram_addr", smp[0].ram_addr, 'h10);
      chk("wr_ram_we", smp[0].ram_we, 1);
      chk("wr_ram_wdata", smp[0].ram_wdata, 'h5A);
      chk("rb_ready", smp[0].rb_ready, 1);
      rv = 0;
      cycle();
      cycle();
      chk("rb_dv", smp[0].rb_dv, 1);
      chk("rb_data", smp[0].rb_data, 'h5A);

      // continuous display: writer blocked, starvation flag, 2-cycle read lag
      idle_inputs(); vb = 1;
      wv = 1; wa = AW'(5); wd = 8'h77; disp = 1;
      cnt = 0; starve_at = -1;
      for (int i = 0; i < 640; i++) begin
         da = AW'(1024 + i);
         cycle();
         if (smp[0].wr_ready !== 1'b0) cnt++;
         if (starve_at < 0 && smp[0].starved === 1'b1) starve_at = i;
         if (i >= 2) chk("disp_lag", smp[0].disp_data, pat(1024 + i - 2));
      end
      chk("disp_wr_blocked", cnt, 0);
      chk("starve_rise", starve_at, 16);
      disp = 0;
      cycle();

      // frame lock gating and frame write count
      idle_inputs();
      do_reset(1);
      wv = 1; wa = AW'(7); wd = 8'h01;
      cycle();
      chk("lock_blocked", smp[1].wr_ready, 0);
      chk("nolock_granted", smp[0].wr_ready, 1);
      repeat (3) cycle();
      vb = 1;
      cycle();
      chk("lock_vblank_grant", smp[1].wr_ready, 1);
      do_reset(1);
      wv = 1; vb = 1;
      for (int i = 0; i < 37; i++) begin
         wa = AW'(400 + i); wd = DW'($urandom);
         cycle();
      end
      wv = 0; fs = 1;
      cycle();
      fs = 0;
      cycle();
      chk("fwc37_lock", smp[1].fwc, 37);
      chk("fwc37_nolock", smp[0].fwc, 37);

      // readback dropped by a reset on the following cycle
      idle_inputs();
      rv = 1; ra = AW'(9);
      cycle();
      chk("drop_rb_hs", smp[0].rb_ready, 1);
      rv = 0; rst_n = 0;
      cycle();
      rst_n = 1;
      cnt = 0;
      repeat (4) begin
         cycle();
         if (smp[0].rb_dv !== 1'b0 || smp[1].rb_dv !== 1'b0) cnt++;
      end
      chk("drop_rb_dv", cnt, 0);

      // randomized traffic against the reference models
      for (int i = 0; i < 3000; i++) begin
         rst_n = ($urandom_range(0, 199) != 0);
         fs    = ($urandom_range(0, 49) == 0);
         vb    = $urandom_range(0, 1) == 1;
         disp  = ($urandom_range(0, 9) < (((i / 100) % 3 == 0) ? 9 : 3));
         wv    = ($urandom_range(0, 9) < 6);
         rv    = $urandom_range(0, 1) == 1;
         da    = AW'($urandom_range(0, 63));
         wa    = AW'($urandom_range(0, 63));
         ra    = AW'($urandom_range(0, 63));
         wd    = DW'($urandom);
         cycle();
      end
      rst_n = 1;
      idle_inputs();
      repeat (4) cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
